phase_timer: RTL and testbench
==============================

// Module: phase_timer
// PURPOSE
//  Countdown timer that serves the traffic-light controller's timer handshake.
//  The controller issues t_start with a duration in seconds (t_length).
//  The block counts that duration down using a clock prescaler.
//  During the final seconds it emits periodic t_flicker pulses (green blink).
//  On expiry it emits a t_flicker pulse followed by a t_done pulse.
// PARAMETERS
//  TICK_DIV        50_000_000  clk cycles per second (>=2)
//  FLICKER_WINDOW  5'd5        periodic flicker active while 0 < remaining <= this
//  FLICK_PERIOD    25_000_000  clk cycles between periodic flicker pulses (>=2)
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  asynchronous, active-high
//  t_start      in   1  load t_length and (re)start countdown; sampled every edge
//  t_length     in   5  duration in seconds; sampled only on edges where t_start=1
//  t_flicker    out  1  single-cycle pulse: periodic blink or expiry pre-pulse
//  t_done       out  1  single-cycle pulse: countdown finished
//  t_busy       out  1  high while counting (RUN, EXP_F)
//  t_remaining  out  5  whole seconds left
// BEHAVIOUR
//  - Reset (async): state=IDLE; prescaler=0; flicker counter=0.
//    All outputs are 0: t_flicker, t_done, t_busy, t_remaining.
//  - All outputs are registered. There is no combinational input->output path.
//  - States:
//    - IDLE: waits for t_start.
//    - RUN: counting down.
//    - EXP_F: t_flicker=1 for one cycle.
//    - EXP_D: t_done=1 for one cycle, then IDLE.
//  - t_start=1 at edge 0 (any state), captured length L:
//    - remaining<=L, prescaler<=0, flicker counter<=0.
//    - Next state is RUN if L>0, otherwise EXP_F.
//  - RUN, each edge:
//    - prescaler increments.
//    - When prescaler==TICK_DIV-1: prescaler<=0 and remaining decrements.
//    - When remaining reaches 0: next state EXP_F.
//  - Latency for L>0:
//    - t_flicker is high in the cycle after edge L*TICK_DIV.
//    - t_done is high in the cycle after edge L*TICK_DIV+1.
//  - Latency for L=0: t_flicker after edge 1, t_done after edge 2.
//  - Periodic flicker, active in RUN while 0 < remaining <= FLICKER_WINDOW:
//    - The flicker counter restarts at 0 on window entry (or on load if L<=W).
//    - t_flicker pulses at window-entry edge + k*FLICK_PERIOD, for k>=1.
//  - Pulse-spacing rule:
//    - t_flicker is never high in two consecutive cycles.
//    - A periodic pulse that would fall in the cycle immediately before the
//      expiry pulse is suppressed.
//    - A periodic pulse that coincides with the expiry pulse merges into it.
//    - This guarantees the controller sees t_done while in its flicker state.
//  - t_done is high only in EXP_D. It is never high in the cycle after a
//    periodic pulse.
//  - t_start during RUN or EXP_F:
//    - Reloads and restarts the countdown.
//    - Any pending expiry or t_done is cancelled.
//  - t_start during EXP_D:
//    - t_done is still emitted that cycle.
//    - The new run begins at that edge (back-to-back phases).
//  - t_remaining tracks the remaining count. It holds 0 in EXP_F, EXP_D and IDLE.
//  - Async reset mid-run aborts immediately: no t_done is emitted.
// TESTING  (TICK_DIV=4, FLICKER_WINDOW=2, FLICK_PERIOD=3 unless stated)
//  - Basic run: L=3 at edge 0.
//    - t_remaining steps 3,2,1,0 at edges 4,8,12.
//    - Periodic t_flicker after edges 7 and 10.
//    - Expiry t_flicker after edge 12; t_done after edge 13; then IDLE, t_busy=0.
//  - Suppression: FLICK_PERIOD=7, L=3.
//    - The periodic pulse at edge 11 is absent.
//    - Only the expiry pulses appear (flicker after edge 12, done after edge 13).
//  - Zero length: L=0 -> t_flicker after edge 1, t_done after edge 2;
//    t_busy high only for the EXP_F cycle.
//  - Restart: L=3, then t_start with L=1 at edge 5.
//    - No t_done near edge 13.
//    - t_flicker after edge 9, t_done after edge 10.
//  - Back-to-back: t_start with L=1 in the t_done cycle.
//    - t_done is seen.
//    - A new expiry follows 4 edges later.
//  - Reset mid-run (edge 6 of L=3): all outputs 0 asynchronously;
//    no pulses until the next t_start.

Source files
------------

// File: rtl/phase_timer.sv
// Countdown timer for the traffic-light controller: seconds prescaler,
// periodic green-blink pulses near the end, expiry flicker then done pulse.
module phase_timer #(
    parameter int unsigned TICK_DIV       = 50_000_000,
    parameter logic [4:0]  FLICKER_WINDOW = 5'd5,
    parameter int unsigned FLICK_PERIOD   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t_start,
    input  logic [4:0] t_length,
    output logic       t_flicker,
    output logic       t_done,
    output logic       t_busy,
    output logic [4:0] t_remaining
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned FW = $clog2(FLICK_PERIOD);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_PENULT = PW'(TICK_DIV - 2);
    localparam logic [FW-1:0] FLICK_LAST = FW'(FLICK_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, RUN, EXP_F, EXP_D} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [FW-1:0] flick_cnt;
    logic          tick;
    logic          in_window;
    logic          pre_expiry;

    always_comb begin
        tick       = (prescaler == PRE_LAST);
        in_window  = (t_remaining != 5'd0) && (t_remaining <= FLICKER_WINDOW);
        // next edge is the expiry edge: a periodic pulse now would abut the expiry pulse
        pre_expiry = (t_remaining == 5'd1) && (prescaler == PRE_PENULT);
    end

    // The RUN-to-expiry edge raises the expiry flicker itself and jumps to EXP_D,
    // so EXP_F is only traversed for zero-length loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prescaler   <= '0;
            flick_cnt   <= '0;
            t_flicker   <= 1'b0;
            t_done      <= 1'b0;
            t_busy      <= 1'b0;
            t_remaining <= '0;
        end else begin
            t_flicker <= 1'b0;
            t_done    <= 1'b0;
            if (t_start) begin
                t_remaining <= t_length;
                prescaler   <= '0;
                flick_cnt   <= '0;
                if (t_length != 5'd0) begin
                    state  <= RUN;
                    t_busy <= 1'b1;
                end else begin
                    state  <= EXP_F;
                    t_busy <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: t_busy <= 1'b0;
                    RUN: begin
                        prescaler <= tick ? '0 : prescaler + 1'b1;
                        if (tick)
                            t_remaining <= t_remaining - 5'd1;
                        if (tick && t_remaining == 5'd1) begin
                            t_flicker <= 1'b1;
                            state     <= EXP_D;
                        end else if (tick && (t_remaining - 5'd1) == FLICKER_WINDOW) begin
                            flick_cnt <= '0;
                        end else if (in_window) begin
                            if (flick_cnt == FLICK_LAST) begin
                                flick_cnt <= '0;
                                t_flicker <= !pre_expiry;
                            end else begin
                                flick_cnt <= flick_cnt + 1'b1;
                            end
                        end
                    end
                    EXP_F: begin
                        t_flicker <= 1'b1;
                        t_busy    <= 1'b1;
                        state     <= EXP_D;
                    end
                    EXP_D: begin
                        t_done <= 1'b1;
                        t_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: two instances (blink period 3 and 7) driven by the same
// directed and random stimulus, checked against an edge-indexed schedule model.
module tb_phase_timer;

    localparam int TD = 4;
    localparam int W  = 2;
    localparam int PA = 3;
    localparam int PB = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       t_start;
    logic [4:0] t_length;
    logic       a_flicker, a_done, a_busy;
    logic [4:0] a_remaining;
    logic       b_flicker, b_done, b_busy;
    logic [4:0] b_remaining;

    always #5 clk = ~clk;

    phase_timer #(.TICK_DIV(TD), .FLICKER_WINDOW(5'(W)), .FLICK_PERIOD(PA)) dut_a (
        .clk(clk), .reset(reset), .t_start(t_start), .t_length(t_length),
        .t_flicker(a_flicker), .t_done(a_done), .t_busy(a_busy), .t_remaining(a_remaining)
    );

    phase_timer #(.TICK_DIV(TD), .FLICKER_WINDOW(5'(W)), .FLICK_PERIOD(PB)) dut_b (
        .clk(clk), .reset(reset), .t_start(t_start), .t_length(t_length),
        .t_flicker(b_flicker), .t_done(b_done), .t_busy(b_busy), .t_remaining(b_remaining)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int start_e = 0;
    int start_l = 0;
    bit has_run = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        if (obs !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Expected outputs after edge edge_n, from the most recent load: expiry at
    // L*TD edges after the load, done one edge later, blinks every p edges after
    // window entry except the one just before expiry.
    function automatic void model(input int p, output int rem, output int busy,
                                  output int flick, output int done);
        int d, x, eo;
        rem = 0; busy = 0; flick = 0; done = 0;
        if (!has_run) return;
        d = edge_n - start_e;
        if (start_l == 0) begin
            busy  = int'(d == 1);
            flick = int'(d == 1);
            done  = int'(d == 2);
            return;
        end
        x  = start_l * TD;
        eo = (start_l <= W) ? 0 : (start_l - W) * TD;
        if (d < x) rem = start_l - d / TD;
        busy  = int'(d <= x);
        done  = int'(d == x + 1);
        flick = int'((d == x) || (d < x - 1 && d > eo && (d - eo) % p == 0));
    endfunction

    task automatic compare_all();
        int r, b, f, d;
        model(PA, r, b, f, d);
        check("a_remaining", 32'(a_remaining), r);
        check("a_busy", 32'(a_busy), b);
        check("a_flicker", 32'(a_flicker), f);
        check("a_done", 32'(a_done), d);
        model(PB, r, b, f, d);
        check("b_remaining", 32'(b_remaining), r);
        check("b_busy", 32'(b_busy), b);
        check("b_flicker", 32'(b_flicker), f);
        check("b_done", 32'(b_done), d);
    endtask

    task automatic cycle(input bit s, input logic [4:0] l);
        t_start  = s;
        t_length = s ? l : 5'($urandom);
        @(posedge clk);
        edge_n++;
        if (s && !reset) begin
            has_run = 1'b1;
            start_e = edge_n;
            start_l = int'(l);
        end
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        has_run = 1'b0;
        #1 compare_all();
        cycle(1'b0, 5'd0);
        #2 reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        t_start  = 1'b0;
        t_length = 5'd0;
        #1 compare_all();
        idle(2);
        #2 reset = 1'b0;

        // basic run, zero length, restart, back-to-back, reset mid-run
        cycle(1'b1, 5'd3); idle(18);
        cycle(1'b1, 5'd0); idle(5);
        cycle(1'b1, 5'd3); idle(4); cycle(1'b1, 5'd1); idle(12);
        cycle(1'b1, 5'd1); idle(5); cycle(1'b1, 5'd1); idle(8);
        cycle(1'b1, 5'd3); idle(5); pulse_reset(); idle(16);
        cycle(1'b1, 5'd2); idle(12);
        cycle(1'b1, 5'd5); idle(24);

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4)
                cycle(1'b1, 5'($urandom_range(0, 7)));
            else if (r == 99)
                pulse_reset();
            else
                cycle(1'b0, 5'd0);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
